// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: divides clk into MDC and serialises one
// read or write frame per start, with a split out/oe/in pin for the pad buffer.
module mdio_master #(
  parameter int DIVISOR      = 4,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_write,
  input  logic [4:0]  i_phy_addr,
  input  logic [4:0]  i_reg_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_ta_err,
  output logic        o_mdc,
  output logic        o_mdio_out,
  output logic        o_mdio_oe,
  input  logic        i_mdio
);

  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIVISOR / 2);
  localparam logic [4:0]    PRE_LAST = 5'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

  typedef enum logic [3:0] {IDLE, ARM, PRE, ST, OP, PHYAD, REGAD, TA, DATA} state_t;

  typedef struct packed {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wdata;
  } req_t;

  state_t        state, nxt_state;
  logic [4:0]    bitcnt, nxt_bc;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tick;
  req_t          req, req_in, req_cur;
  logic [14:0]   shreg;
  logic          ta_smp;
  logic [1:0]    drive;

  assign tick    = (cnt == CNT_LAST);
  assign cnt_nxt = tick ? '0 : cnt + CW'(1);
  assign req_in  = '{wr: i_write, phy: i_phy_addr, rg: i_reg_addr, wdata: i_wdata};
  assign req_cur = (state == IDLE) ? req_in : req;

  // {oe, out} for the cell identified by state and remaining-cell count
  function automatic logic [1:0] cell_drive(input state_t s, input logic [4:0] bc, input req_t r);
    logic [1:0] d;
    d = 2'b01;
    case (s)
      PRE:   d = 2'b11;
      ST:    d = {1'b1, bc == 5'd0};
      OP:    d = {1'b1, r.wr ? (bc == 5'd0) : (bc == 5'd1)};
      PHYAD: d = {1'b1, r.phy[bc[2:0]]};
      REGAD: d = {1'b1, r.rg[bc[2:0]]};
      TA:    d = {r.wr, r.wr ? (bc == 5'd1) : 1'b1};
      DATA:  d = {r.wr, r.wr ? r.wdata[bc[3:0]] : 1'b1};
      default: d = 2'b01;
    endcase
    return d;
  endfunction

  // Each state holds bitcnt = cells remaining after the current one
  always_comb begin
    nxt_state = state;
    nxt_bc    = bitcnt - 5'd1;
    case (state)
      IDLE, ARM: begin
        nxt_state = (PREAMBLE_LEN > 0) ? PRE : ST;
        nxt_bc    = (PREAMBLE_LEN > 0) ? PRE_LAST : 5'd1;
      end
      PRE:   if (bitcnt == 5'd0) begin nxt_state = ST;    nxt_bc = 5'd1;  end
      ST:    if (bitcnt == 5'd0) begin nxt_state = OP;    nxt_bc = 5'd1;  end
      OP:    if (bitcnt == 5'd0) begin nxt_state = PHYAD; nxt_bc = 5'd4;  end
      PHYAD: if (bitcnt == 5'd0) begin nxt_state = REGAD; nxt_bc = 5'd4;  end
      REGAD: if (bitcnt == 5'd0) begin nxt_state = TA;    nxt_bc = 5'd1;  end
      TA:    if (bitcnt == 5'd0) begin nxt_state = DATA;  nxt_bc = 5'd15; end
      DATA:  if (bitcnt == 5'd0) begin nxt_state = IDLE;  nxt_bc = 5'd0;  end
      default: begin nxt_state = IDLE; nxt_bc = 5'd0; end
    endcase
  end

  assign drive = cell_drive(nxt_state, nxt_bc, req_cur);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      cnt        <= '0;
      o_mdc      <= 1'b0;
      state      <= IDLE;
      bitcnt     <= '0;
      req        <= '0;
      shreg      <= '0;
      ta_smp     <= 1'b0;
      o_mdio_out <= 1'b1;
      o_mdio_oe  <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rdata    <= '0;
      o_ta_err   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      o_mdc  <= (cnt_nxt >= CNT_HALF);
      o_done <= 1'b0;
      if (state == IDLE && i_start) begin
        req    <= req_in;
        o_busy <= 1'b1;
        state  <= ARM;
      end
      // Cell boundary: sample the ending cell, then present the next one
      if (tick && (state != IDLE || i_start)) begin
        state                   <= nxt_state;
        bitcnt                  <= nxt_bc;
        {o_mdio_oe, o_mdio_out} <= drive;
        o_busy                  <= (nxt_state != IDLE);
        o_done                  <= (nxt_state == IDLE);
        if (state == TA && bitcnt == 5'd0) ta_smp <= i_mdio;
        if (state == DATA) begin
          shreg <= {shreg[13:0], i_mdio};
          if (nxt_state == IDLE && !req.wr) begin
            o_rdata  <= {shreg, i_mdio};
            o_ta_err <= ta_smp;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: cycle-level frame model plus directed transactions.
module tb_mdio_master;
  localparam int D  = 4;
  localparam int P  = 32;
  localparam int NC = P + 32;
  localparam int D2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset = 1'b1, i_start = 1'b0, i_write = 1'b0, i_mdio = 1'b1;
  logic [4:0]  i_phy_addr = '0, i_reg_addr = '0;
  logic [15:0] i_wdata = '0;
  logic [15:0] o_rdata;
  logic        o_done, o_busy, o_ta_err, o_mdc, o_mdio_out, o_mdio_oe;

  logic        start2 = 1'b0;
  logic [15:0] rdata2;
  logic        done2, busy2, ta_err2, mdc2, out2, oe2;

  mdio_master #(.DIVISOR(D), .PREAMBLE_LEN(P)) dut (
    .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_write(i_write),
    .i_phy_addr(i_phy_addr), .i_reg_addr(i_reg_addr), .i_wdata(i_wdata),
    .o_rdata(o_rdata), .o_done(o_done), .o_busy(o_busy), .o_ta_err(o_ta_err),
    .o_mdc(o_mdc), .o_mdio_out(o_mdio_out), .o_mdio_oe(o_mdio_oe), .i_mdio(i_mdio));

  mdio_master #(.DIVISOR(D2), .PREAMBLE_LEN(0)) dut2 (
    .clk(clk), .i_reset(i_reset), .i_start(start2), .i_write(1'b0),
    .i_phy_addr(5'h03), .i_reg_addr(5'h11), .i_wdata(16'h0000),
    .o_rdata(rdata2), .o_done(done2), .o_busy(busy2), .o_ta_err(ta_err2),
    .o_mdc(mdc2), .o_mdio_out(out2), .o_mdio_oe(oe2), .i_mdio(1'b1));

  int n_tests = 0, n_fail = 0, n_done = 0;

  // frame model state, updated once per clock edge
  int          m_cyc = 0, m_a = 0, m_fa = 0, m_end = 0, m_done_c = -1;
  bit          chk_en = 0, m_on = 0, m_rd = 0, m_resp = 0;
  logic [15:0] m_pdata = '0, m_rdata = '0;
  logic        m_ta = 1'b0;
  logic        m_bit [NC];
  logic        m_oe  [NC];
  logic        t_resp = 1'b0;
  logic [15:0] t_pdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, m_cyc);
    end
  endtask

  always @(posedge clk) begin
    if (i_reset) begin
      m_cyc = 0; chk_en = 1; m_on = 0; m_done_c = -1; m_rdata = '0; m_ta = 1'b0;
    end else begin
      if (!m_on && i_start) begin
        m_on = 1; m_a = m_cyc;
        m_fa = m_cyc + D - (m_cyc % D);
        m_end = m_fa + NC * D;
        m_rd = !i_write; m_resp = t_resp; m_pdata = t_pdata;
        for (int k = 0; k < NC; k++) m_oe[k] = 1'b1;
        for (int k = 0; k < P; k++) m_bit[k] = 1'b1;
        m_bit[P] = 1'b0; m_bit[P+1] = 1'b1;
        m_bit[P+2] = m_rd; m_bit[P+3] = !m_rd;
        for (int i = 0; i < 5; i++) begin
          m_bit[P+4+i] = i_phy_addr[4-i];
          m_bit[P+9+i] = i_reg_addr[4-i];
        end
        m_bit[P+14] = 1'b1; m_bit[P+15] = 1'b0;
        for (int i = 0; i < 16; i++) m_bit[P+16+i] = i_wdata[15-i];
        if (m_rd) for (int k = P + 14; k < NC; k++) m_oe[k] = 1'b0;
      end
      m_cyc++;
      if (m_on && m_cyc == m_end) begin
        m_on = 0; m_done_c = m_cyc;
        if (m_rd) begin m_rdata = m_resp ? m_pdata : 16'hFFFF; m_ta = !m_resp; end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    int k;
    logic e_oe;
    if (chk_en) begin
      k = 0; e_oe = 1'b0;
      if (m_on && m_cyc >= m_fa) begin k = (m_cyc - m_fa) / D; e_oe = m_oe[k]; end
      chk("mdc", o_mdc, 64'((m_cyc % D) >= D / 2));
      chk("busy", o_busy, 64'(m_on && m_cyc > m_a));
      chk("done", o_done, 64'(m_cyc == m_done_c));
      chk("oe", o_mdio_oe, e_oe);
      if (e_oe) chk("mdio_out", o_mdio_out, m_bit[k]);
      chk("rdata", o_rdata, m_rdata);
      chk("ta_err", o_ta_err, m_ta);
    end
  end

  // PHY: drives TA cell 2 low and the data MSB first when it responds
  always @(negedge clk) begin
    int kp;
    logic v;
    v = 1'b1;
    if (m_on && m_rd && m_resp && m_cyc >= m_fa) begin
      kp = (m_cyc - m_fa) / D;
      if (kp == P + 15) v = 1'b0;
      else if (kp >= P + 16) v = m_pdata[15-(kp-P-16)];
    end
    i_mdio = v;
  end

  logic [63:0] cap = '0, capoe = '0, cap2 = '0, capoe2 = '0;
  logic        mdc_p = 1'b0, oe_p = 1'b0, mdc2_p = 1'b0, oe2_p = 1'b0;
  int          oe_rise_t = 0, oe2_rise_t = 0;

  always @(negedge clk) begin
    if (o_done === 1'b1) n_done++;
    if (o_mdc === 1'b1 && !mdc_p) begin cap = {cap[62:0], o_mdio_out}; capoe = {capoe[62:0], o_mdio_oe}; end
    if (o_mdio_oe === 1'b1 && !oe_p) oe_rise_t = m_cyc;
    mdc_p = (o_mdc === 1'b1); oe_p = (o_mdio_oe === 1'b1);
    if (mdc2 === 1'b1 && !mdc2_p) begin cap2 = {cap2[62:0], out2}; capoe2 = {capoe2[62:0], oe2}; end
    if (oe2 === 1'b1 && !oe2_p) oe2_rise_t = m_cyc;
    mdc2_p = (mdc2 === 1'b1); oe2_p = (oe2 === 1'b1);
  end

  task automatic pulse_start(input logic wr, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd);
    i_start = 1'b1; i_write = wr; i_phy_addr = phy; i_reg_addr = rg; i_wdata = wd;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int t);
    t = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin t = m_cyc; return; end
    end
    chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int t, t1, nd;
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0); chk("rst_oe", o_mdio_oe, 0); chk("rst_out", o_mdio_out, 1);
    chk("rst_mdc", o_mdc, 0); chk("rst_rdata", o_rdata, 0); chk("rst_done", o_done, 0);
    i_reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: write 0x1140 to phy 1 reg 0
    nd = n_done;
    pulse_start(1'b1, 5'h01, 5'h00, 16'h1140);
    wait_done("t1", t);
    chk("t1_stream", cap, {32'hFFFF_FFFF, 32'h5082_1140});
    chk("t1_oe", capoe, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_len", 64'(t - oe_rise_t), 64'd256);
    repeat (3) @(negedge clk);
    chk("t1_ndone", 64'(n_done - nd), 64'd1);

    // 2: read phy 1 reg 2, PHY returns 0x0007
    t_resp = 1'b1; t_pdata = 16'h0007;
    repeat (2) @(negedge clk);
    pulse_start(1'b0, 5'h01, 5'h02, 16'hDEAD);
    wait_done("t2", t);
    chk("t2_hdr", cap[63:18], {32'hFFFF_FFFF, 14'b01100000100010});
    chk("t2_oe", capoe, 64'hFFFF_FFFF_FFFC_0000);
    chk("t2_rdata", o_rdata, 16'h0007);
    chk("t2_ta", o_ta_err, 0);
    chk("t2_len", 64'(t - oe_rise_t), 64'd256);

    // 3: read with nobody answering
    t_resp = 1'b0;
    repeat (3) @(negedge clk);
    pulse_start(1'b0, 5'h01, 5'h03, 16'h0000);
    wait_done("t3", t);
    chk("t3_rdata", o_rdata, 16'hFFFF);
    chk("t3_ta", o_ta_err, 1);

    // 4: ignored mid-frame start, then back-to-back start in the done cycle
    t_resp = 1'b1; t_pdata = 16'hBEEF;
    repeat (1) @(negedge clk);
    nd = n_done;
    pulse_start(1'b1, 5'h1F, 5'h1F, 16'hA5C3);
    repeat (100) @(negedge clk);
    pulse_start(1'b0, 5'h02, 5'h04, 16'h0000);
    wait_done("t4a", t1);
    pulse_start(1'b0, 5'h0A, 5'h15, 16'h0000);
    wait_done("t4b", t);
    chk("t4_align", 64'(oe_rise_t - t1), 64'(D));
    chk("t4_rdata", o_rdata, 16'hBEEF);
    repeat (3) @(negedge clk);
    chk("t4_ndone", 64'(n_done - nd), 64'd2);

    // 5: reset while PHYAD is on the wire
    t_pdata = 16'h1234;
    pulse_start(1'b0, 5'h07, 5'h09, 16'h0000);
    for (int i = 0; i < 1000 && !(m_on && m_cyc >= m_fa + (P + 6) * D); i++) @(negedge clk);
    chk("t5_reach", 64'(m_on && m_cyc >= m_fa + (P + 6) * D), 64'd1);
    i_reset = 1'b1;
    @(negedge clk);
    chk("t5_oe", o_mdio_oe, 0); chk("t5_busy", o_busy, 0);
    i_reset = 1'b0;
    nd = n_done;
    repeat (300) @(negedge clk);
    chk("t5_nodone", 64'(n_done), 64'(nd));
    t_pdata = 16'h8001;
    pulse_start(1'b0, 5'h05, 5'h1F, 16'h0000);
    wait_done("t5", t);
    chk("t5_rdata", o_rdata, 16'h8001);
    chk("t5_ta", o_ta_err, 0);

    // 6: no preamble, DIVISOR=2 read of phy 3 reg 0x11
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    t = -1;
    for (int i = 0; i < 500 && t < 0; i++) begin
      @(negedge clk);
      if (done2 === 1'b1) t = m_cyc;
    end
    chk("t6_done", 64'(t >= 0), 64'd1);
    chk("t6_len", 64'(t - oe2_rise_t), 64'(32 * D2));
    chk("t6_hdr", cap2[31:18], 14'b01100001110001);
    chk("t6_oe", capoe2[32:0], 64'h0_FFFC_0000);
    chk("t6_rdata", rdata2, 16'hFFFF);
    chk("t6_ta", ta_err2, 1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
